// File: rtl/im_loader.sv
// im_loader: receives a length-prefixed little-endian byte stream and writes it into instruction memory
module im_loader #(
    parameter int ADDR_W    = 16,
    parameter int MAX_WORDS = 32,
    parameter int TIMEOUT   = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_rst
);
    localparam int WI = $clog2(MAX_WORDS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERR} state_t;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [WI-1:0]     widx_q, widx_d;
    logic [1:0]        bidx_q, bidx_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [23:0]       buf_q, buf_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              acc, last;
    logic [15:0]       n;

    assign rx_ready = state_q == LEN0 || state_q == LEN1 || state_q == DATA;
    assign we       = state_q == WRITE;
    assign busy     = !(state_q == IDLE || state_q == DONE || state_q == ERR);
    assign done     = state_q == DONE;
    assign err      = state_q == ERR;
    assign cpu_rst  = state_q != DONE;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign acc      = rx_valid && rx_ready;
    assign n        = {rx_data, len_q[7:0]};
    assign last     = (16'(widx_q) + 16'd1) == len_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        widx_d  = widx_q;
        bidx_d  = bidx_q;
        tmo_d   = tmo_q;
        buf_d   = buf_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LEN0;
                    widx_d  = '0;
                    bidx_d  = '0;
                    tmo_d   = '0;
                end
            end
            LEN0, LEN1, DATA: begin
                tmo_d = acc ? '0 : tmo_q + 1'b1;
                // the edge on which the idle count reaches TIMEOUT is the edge that enters ERR
                if (!acc && tmo_q == TMO_LAST) begin
                    state_d = ERR;
                end else if (acc && state_q == LEN0) begin
                    len_d[7:0] = rx_data;
                    state_d    = LEN1;
                end else if (acc && state_q == LEN1) begin
                    len_d[15:8] = rx_data;
                    state_d     = n == 16'd0 ? DONE : n > 16'(MAX_WORDS) ? ERR : DATA;
                end else if (acc) begin
                    buf_d  = {rx_data, buf_q[23:8]};
                    bidx_d = bidx_q + 1'b1;
                    if (bidx_q == 2'd3) begin
                        state_d = WRITE;
                        wdata_d = {rx_data, buf_q};
                        waddr_d = ADDR_W'({widx_q, 2'b00});
                    end
                end
            end
            WRITE: begin
                state_d = last ? DONE : DATA;
                widx_d  = last ? widx_q : widx_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            widx_q  <= '0;
            bidx_q  <= '0;
            tmo_q   <= '0;
            buf_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            widx_q  <= widx_d;
            bidx_q  <= bidx_d;
            tmo_q   <= tmo_d;
            buf_q   <= buf_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: directed scenario tasks for im_loader with a negedge write logger
module tb_im_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready, we, busy, done, err, cpu_rst;
    logic [15:0] waddr;
    logic [31:0] wdata;
    int          checks = 0;
    int          failures = 0;
    logic [15:0] wa_log[$];
    logic [31:0] wd_log[$];

    im_loader #(.ADDR_W(16), .MAX_WORDS(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .we(we), .waddr(waddr), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .cpu_rst(cpu_rst)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we === 1'b1) begin
            wa_log.push_back(waddr);
            wd_log.push_back(wdata);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        wa_log.delete();
        wd_log.delete();
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_byte %02h: rx_ready=%b after %0d cycles, required 1", b, rx_ready, n);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({rx_ready, we, busy, done, err, cpu_rst} !== 6'b000001) begin
            failures++;
            $display("FAIL reset_flags: got %b required 000001", {rx_ready, we, busy, done, err, cpu_rst});
        end
        checks++;
        if (waddr !== 16'h0 || wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_bus: waddr=%h wdata=%h required 0/0", waddr, wdata);
        end
        rst = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        checks++;
        if ({rx_ready, busy, done, err} !== 4'b0000) begin
            failures++;
            $display("FAIL idle_ignores_rx: flags=%b required 0000", {rx_ready, busy, done, err});
        end
    endtask

    task automatic test_load3();
        logic [7:0] bytes[14] = '{8'h03, 8'h00, 8'h13, 8'h05, 8'hc0, 8'h00, 8'h93, 8'h05,
                                  8'h90, 8'h00, 8'h33, 8'h06, 8'hb5, 8'h40};
        clear_log();
        do_start();
        checks++;
        if ({busy, cpu_rst, rx_ready} !== 3'b111) begin
            failures++;
            $display("FAIL load3_start: busy/cpu_rst/rx_ready=%b required 111", {busy, cpu_rst, rx_ready});
        end
        foreach (bytes[i]) send_byte(bytes[i]);
        checks++;
        if (we !== 1'b1 || waddr !== 16'h8 || wdata !== 32'h40b50633) begin
            failures++;
            $display("FAIL load3_we_latency: we=%b waddr=%h wdata=%h required 1/0008/40b50633", we, waddr, wdata);
        end
        @(negedge clk);
        checks++;
        if ({done, cpu_rst, busy, we} !== 4'b1000) begin
            failures++;
            $display("FAIL load3_done: done/cpu_rst/busy/we=%b required 1000", {done, cpu_rst, busy, we});
        end
        checks++;
        if (wa_log.size() != 3) begin
            failures++;
            $display("FAIL load3_count: writes=%0d required 3", wa_log.size());
        end else begin
            checks++;
            if (wa_log[0] !== 16'h0 || wd_log[0] !== 32'h00c00513) begin
                failures++;
                $display("FAIL load3_w0: (%h,%h) required (0000,00c00513)", wa_log[0], wd_log[0]);
            end
            checks++;
            if (wa_log[1] !== 16'h4 || wd_log[1] !== 32'h00900593) begin
                failures++;
                $display("FAIL load3_w1: (%h,%h) required (0004,00900593)", wa_log[1], wd_log[1]);
            end
            checks++;
            if (wa_log[2] !== 16'h8 || wd_log[2] !== 32'h40b50633) begin
                failures++;
                $display("FAIL load3_w2: (%h,%h) required (0008,40b50633)", wa_log[2], wd_log[2]);
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (waddr !== 16'h8 || wdata !== 32'h40b50633 || we !== 1'b0) begin
            failures++;
            $display("FAIL load3_hold: we=%b waddr=%h wdata=%h required 0/0008/40b50633", we, waddr, wdata);
        end
    endtask

    task automatic test_n0();
        clear_log();
        do_start();
        send_byte(8'h00);
        send_byte(8'h00);
        checks++;
        if ({done, cpu_rst, err} !== 3'b100) begin
            failures++;
            $display("FAIL n0_done: done/cpu_rst/err=%b required 100", {done, cpu_rst, err});
        end
        checks++;
        if (wa_log.size() != 0) begin
            failures++;
            $display("FAIL n0_nowrite: writes=%0d required 0", wa_log.size());
        end
    endtask

    task automatic test_n33();
        clear_log();
        do_start();
        send_byte(8'h21);
        send_byte(8'h00);
        checks++;
        if ({err, cpu_rst, done, busy} !== 4'b1100) begin
            failures++;
            $display("FAIL n33_err: err/cpu_rst/done/busy=%b required 1100", {err, cpu_rst, done, busy});
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wa_log.size() != 0 || err !== 1'b1) begin
            failures++;
            $display("FAIL n33_nowrite: writes=%0d err=%b required 0/1", wa_log.size(), err);
        end
    endtask

    task automatic test_backpressure_timeout();
        logic [7:0] bytes[4] = '{8'h13, 8'h05, 8'hc0, 8'h00};
        clear_log();
        do_start();
        send_byte(8'h01);
        send_byte(8'h00);
        foreach (bytes[i]) begin
            @(negedge clk);
            send_byte(bytes[i]);
        end
        @(negedge clk);
        checks++;
        if (wa_log.size() != 1) begin
            failures++;
            $display("FAIL bp_count: writes=%0d required 1", wa_log.size());
        end else begin
            checks++;
            if (wa_log[0] !== 16'h0 || wd_log[0] !== 32'h00c00513) begin
                failures++;
                $display("FAIL bp_word: (%h,%h) required (0000,00c00513)", wa_log[0], wd_log[0]);
            end
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL bp_done: done=%b required 1", done);
        end
        clear_log();
        do_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'haa);
        send_byte(8'hbb);
        repeat (15) @(negedge clk);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL tmo_early: err=%b busy=%b after 15 idle cycles required 0/1", err, busy);
        end
        @(negedge clk);
        checks++;
        if ({err, busy, cpu_rst} !== 3'b101) begin
            failures++;
            $display("FAIL tmo_err: err/busy/cpu_rst=%b after 16 idle cycles required 101", {err, busy, cpu_rst});
        end
        checks++;
        if (wa_log.size() != 0) begin
            failures++;
            $display("FAIL tmo_nowrite: writes=%0d required 0", wa_log.size());
        end
    endtask

    task automatic test_reset_mid_word();
        clear_log();
        do_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({rx_ready, we, busy, done, err, cpu_rst} !== 6'b000001 || waddr !== 16'h0 || wdata !== 32'h0) begin
            failures++;
            $display("FAIL midrst_state: flags=%b waddr=%h wdata=%h required 000001/0000/00000000",
                     {rx_ready, we, busy, done, err, cpu_rst}, waddr, wdata);
        end
        do_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h44);
        send_byte(8'h33);
        send_byte(8'h22);
        send_byte(8'h11);
        @(negedge clk);
        checks++;
        if (wa_log.size() != 1) begin
            failures++;
            $display("FAIL midrst_count: writes=%0d required 1", wa_log.size());
        end else begin
            checks++;
            if (wa_log[0] !== 16'h0 || wd_log[0] !== 32'h11223344) begin
                failures++;
                $display("FAIL midrst_word: (%h,%h) required (0000,11223344)", wa_log[0], wd_log[0]);
            end
        end
    endtask

    task automatic test_restart();
        clear_log();
        rx_valid = 1'b1;
        rx_data  = 8'h77;
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        checks++;
        if ({done, rx_ready, cpu_rst} !== 3'b100) begin
            failures++;
            $display("FAIL done_ignores_rx: done/rx_ready/cpu_rst=%b required 100", {done, rx_ready, cpu_rst});
        end
        do_start();
        checks++;
        if ({cpu_rst, busy, done} !== 3'b110) begin
            failures++;
            $display("FAIL restart_state: cpu_rst/busy/done=%b required 110", {cpu_rst, busy, done});
        end
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hef);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'hbe);
        send_byte(8'had);
        send_byte(8'hde);
        @(negedge clk);
        checks++;
        if (wa_log.size() != 1) begin
            failures++;
            $display("FAIL restart_count: writes=%0d required 1", wa_log.size());
        end else begin
            checks++;
            if (wa_log[0] !== 16'h0 || wd_log[0] !== 32'hdeadbeef) begin
                failures++;
                $display("FAIL restart_word: (%h,%h) required (0000,deadbeef)", wa_log[0], wd_log[0]);
            end
        end
        checks++;
        if ({done, cpu_rst} !== 2'b10) begin
            failures++;
            $display("FAIL restart_done: done/cpu_rst=%b required 10", {done, cpu_rst});
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_load3();
        test_n0();
        test_n33();
        test_backpressure_timeout();
        test_reset_mid_word();
        test_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
